board_scan_source: RTL and testbench
====================================

Name: board_scan_source

Overview:
- Producer side of the per-cell pixel-colour lookup interface: owns the board state and drives `local_v`, `local_h` and `cell_value` for every scanned pixel.
- Holds a `ROWS x COLS` array of 2-bit cell codes: 00 empty, 01 black, 10 white, 11 illegal.
- Game logic writes the array through a single write port.
- The display path feeds raw pixel coordinates plus syncs in. The block returns the lookup inputs with a fixed 2-cycle latency, syncs delayed to match.

Parameters:
- COLS, 10, board columns; 64-pixel cells.
- ROWS, 7, board rows.
- ORIGIN_H, 0, first horizontal pixel of the board.
- ORIGIN_V, 16, first vertical pixel of the board.
- PIX_W, 10, width of pixel coordinate inputs.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- pix_h  in  PIX_W  current horizontal pixel.
- pix_v  in  PIX_W  current vertical pixel.
- pix_de  in  1  display-enable for this pixel.
- hsync_in  in  1  raw hsync.
- vsync_in  in  1  raw vsync.
- wr_en  in  1  write strobe.
- wr_row  in  4  target row.
- wr_col  in  4  target column.
- wr_value  in  2  cell code to write.
- clear_req  in  1  request to clear the whole board.
- local_v  out  6  vertical offset inside the cell.
- local_h  out  6  horizontal offset inside the cell.
- cell_value  out  2  code of the addressed cell.
- in_board  out  1  pixel lies on the board.
- de_out  out  1  pix_de delayed by 2.
- hsync_out  out  1  hsync_in delayed by 2.
- vsync_out  out  1  vsync_in delayed by 2.
- busy  out  1  clear in progress.
- wr_err  out  1  one-cycle pulse: last write rejected.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high, on clk/rst.
- Reset values:
  - All cells 00.
  - All outputs 0.
  - Pipeline registers 0.
  - FSM in IDLE.
  - Clear counter 0.
  - A reset asserted mid-clear aborts the clear; the array still ends all-00.
- Stage 1, registered:
  - rel_h = pix_h - ORIGIN_H and rel_v = pix_v - ORIGIN_V, both PIX_W-bit modular.
  - in_board_s1 = pix_de & (pix_h >= ORIGIN_H) & (rel_h < COLS*64) & (pix_v >= ORIGIN_V) & (rel_v < ROWS*64).
  - col = rel_h[9:6], row = rel_v[9:6].
  - local_h = rel_h[5:0], local_v = rel_v[5:0].
  - Syncs and de are registered alongside.
- Stage 2, registered:
  - cell_value = board[row][col] when in_board_s1, else 00.
  - Local coordinates, in_board, de and syncs are passed through unchanged.
- Latency:
  - Exactly 2 cycles from pixel inputs to all outputs.
  - No stalls; a new pixel is accepted every cycle.
- Read/write collision: a stage-2 read of a cell written in the same cycle returns the old value (read-before-write). The new value is visible from the next cycle.
- Write port:
  - A write occurs on the edge where wr_en=1.
  - It is rejected, with wr_err=1 the following cycle, when any of these hold:
    - wr_row >= ROWS
    - wr_col >= COLS
    - wr_value = 11
    - FSM is CLEAR
  - A rejected write changes nothing.
  - Accepted writes unconditionally overwrite; no occupancy check.
- FSM:
  - IDLE: on clear_req=1, go to CLEAR with counter=0 and busy=1.
  - If wr_en and clear_req arrive in the same IDLE cycle, the write is applied first, then cleared.
  - CLEAR: zero cell[counter] in row-major order (row=counter/COLS, col=counter%COLS), one cell per cycle, counter+1.
  - After cell ROWS*COLS-1 is cleared, go to IDLE with busy=0 the next cycle.
  - busy is high for exactly ROWS*COLS cycles, 70 at defaults.
  - clear_req while in CLEAR is ignored; it does not restart the clear.
- Scan reads continue during CLEAR and show partially cleared contents.

Test Plan:
- Write row 2, col 3, value 01, then drive pix_h=197, pix_v=154, pix_de=1. Two cycles later: in_board=1, local_h=5, local_v=10, cell_value=01.
- Drive pix_v=5, pix_h=100, then pix_h=640, pix_v=200. Both give in_board=0 and cell_value=00. Check de_out, hsync_out and vsync_out equal their inputs delayed by exactly 2 cycles.
- Write value 11 to (0,0), then row 7, then col 10. Each gives a wr_err pulse 1 cycle later, and a scan of (0,0) still reads 00.
- Fill (0,0)=10 and (6,9)=01, then pulse clear_req:
  - busy is high for 70 cycles;
  - a write during busy gives wr_err;
  - afterwards both cells read 00.
- Write (1,1)=10 while scanning cell (1,1) continuously: the first stage-2 read in the write cycle shows 00, the next shows 10.
- Pulse clear_req with (4,4)=01, then assert rst at cycle 20 of the clear: busy=0, all outputs 0, FSM IDLE, and (4,4) reads 00.

Source files
------------

// File: rtl/board_scan_source.sv
// rtl/board_scan_source.sv - board cell store and 2-stage pixel-to-cell lookup pipeline
// Owns the ROWS x COLS board of 2-bit codes and feeds per-pixel cell lookups to the renderer.
module board_scan_source #(
  parameter int COLS     = 10,
  parameter int ROWS     = 7,
  parameter int ORIGIN_H = 0,
  parameter int ORIGIN_V = 16,
  parameter int PIX_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_h,
  input  logic [PIX_W-1:0] pix_v,
  input  logic             pix_de,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             wr_en,
  input  logic [3:0]       wr_row,
  input  logic [3:0]       wr_col,
  input  logic [1:0]       wr_value,
  input  logic             clear_req,
  output logic [5:0]       local_v,
  output logic [5:0]       local_h,
  output logic [1:0]       cell_value,
  output logic             in_board,
  output logic             de_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             busy,
  output logic             wr_err
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [PIX_W:0]   ORG_H_X  = (PIX_W+1)'(ORIGIN_H);
  localparam logic [PIX_W:0]   ORG_V_X  = (PIX_W+1)'(ORIGIN_V);
  localparam logic [PIX_W-1:0] SPAN_H   = PIX_W'(COLS * 64);
  localparam logic [PIX_W-1:0] SPAN_V   = PIX_W'(ROWS * 64);
  localparam logic [3:0]       ROWS_L   = 4'(ROWS);
  localparam logic [3:0]       COLS_L   = 4'(COLS);
  localparam logic [IDX_W-1:0] COLS_I   = IDX_W'(COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  // Flat packed store: cell i occupies bits [2i+1:2i], i = row*COLS + col.
  logic [2*CELLS-1:0] board_q;

  logic [PIX_W:0]   diff_h, diff_v;
  logic [PIX_W-1:0] rel_h, rel_v;
  logic             in_board_d;

  logic       s1_in_q, s1_de_q, s1_hs_q, s1_vs_q;
  logic [3:0] s1_row_q, s1_col_q;
  logic [5:0] s1_lh_q, s1_lv_q;

  logic       in_board_q, de_q, hs_q, vs_q, wr_err_q;
  logic [5:0] lh_q, lv_q;
  logic [1:0] cell_q;

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [1:0]       rd_cell;
  logic             wr_ok;

  // The extra top bit of each difference is the borrow, i.e. pixel left of / above the origin.
  assign diff_h     = {1'b0, pix_h} - ORG_H_X;
  assign diff_v     = {1'b0, pix_v} - ORG_V_X;
  assign rel_h      = diff_h[PIX_W-1:0];
  assign rel_v      = diff_v[PIX_W-1:0];
  assign in_board_d = pix_de & ~diff_h[PIX_W] & (rel_h < SPAN_H)
                             & ~diff_v[PIX_W] & (rel_v < SPAN_V);

  assign rd_idx  = IDX_W'(s1_row_q) * COLS_I + IDX_W'(s1_col_q);
  assign rd_cell = s1_in_q ? board_q[{rd_idx, 1'b0} +: 2] : 2'b00;

  assign wr_idx = IDX_W'(wr_row) * COLS_I + IDX_W'(wr_col);
  assign wr_ok  = wr_en & (wr_row < ROWS_L) & (wr_col < COLS_L)
                & (wr_value != 2'b11) & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Writes are locked out during CLEAR, so the two update paths never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      board_q <= '0;
    end else if (state_q == CLEAR) begin
      board_q[{cnt_q, 1'b0} +: 2] <= 2'b00;
    end else if (wr_ok) begin
      board_q[{wr_idx, 1'b0} +: 2] <= wr_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_en & ~wr_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_in_q  <= 1'b0;
      s1_de_q  <= 1'b0;
      s1_hs_q  <= 1'b0;
      s1_vs_q  <= 1'b0;
      s1_row_q <= '0;
      s1_col_q <= '0;
      s1_lh_q  <= '0;
      s1_lv_q  <= '0;
    end else begin
      s1_in_q  <= in_board_d;
      s1_de_q  <= pix_de;
      s1_hs_q  <= hsync_in;
      s1_vs_q  <= vsync_in;
      s1_row_q <= rel_v[9:6];
      s1_col_q <= rel_h[9:6];
      s1_lh_q  <= rel_h[5:0];
      s1_lv_q  <= rel_v[5:0];
    end
  end

  // Reads the pre-update board, so a same-cycle write shows up one pixel later.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_board_q <= 1'b0;
      de_q       <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      lh_q       <= '0;
      lv_q       <= '0;
      cell_q     <= 2'b00;
    end else begin
      in_board_q <= s1_in_q;
      de_q       <= s1_de_q;
      hs_q       <= s1_hs_q;
      vs_q       <= s1_vs_q;
      lh_q       <= s1_lh_q;
      lv_q       <= s1_lv_q;
      cell_q     <= rd_cell;
    end
  end

  assign local_h    = lh_q;
  assign local_v    = lv_q;
  assign cell_value = cell_q;
  assign in_board   = in_board_q;
  assign de_out     = de_q;
  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_board_scan_source.sv
// tb/tb_board_scan_source.sv - self-checking bench for board_scan_source
// Directed stimulus; a cycle model of the board and pixel path is compared every cycle.
module tb_board_scan_source;

  localparam int COLS = 10;
  localparam int ROWS = 7;
  localparam int OH   = 0;
  localparam int OV   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pix_h, pix_v;
  logic       pix_de, hsync_in, vsync_in;
  logic       wr_en, clear_req;
  logic [3:0] wr_row, wr_col;
  logic [1:0] wr_value;
  logic [5:0] local_v, local_h;
  logic [1:0] cell_value;
  logic       in_board, de_out, hsync_out, vsync_out, busy, wr_err;

  always #5 clk = ~clk;

  board_scan_source #(
    .COLS(COLS), .ROWS(ROWS), .ORIGIN_H(OH), .ORIGIN_V(OV), .PIX_W(10)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_h(pix_h), .pix_v(pix_v), .pix_de(pix_de),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_value(wr_value),
    .clear_req(clear_req),
    .local_v(local_v), .local_h(local_h), .cell_value(cell_value),
    .in_board(in_board), .de_out(de_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .busy(busy), .wr_err(wr_err)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: board as a 2-D array, clear as an index walking 0..ROWS*COLS-1.
  int mb [ROWS][COLS];
  bit model_ok = 1'b0;
  int clr_on, clr_idx;
  int m_ib, m_row, m_col, m_lh, m_lv, m_de, m_hs, m_vs;
  int e_ib, e_lh, e_lv, e_cell, e_de, e_hs, e_vs, e_busy, e_err;
  int rh, rv;

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) mb[r][c] = 0;
      clr_on = 0; clr_idx = 0;
      m_ib = 0; m_row = 0; m_col = 0; m_lh = 0; m_lv = 0; m_de = 0; m_hs = 0; m_vs = 0;
      e_ib = 0; e_lh = 0; e_lv = 0; e_cell = 0; e_de = 0; e_hs = 0; e_vs = 0;
      e_busy = 0; e_err = 0;
      model_ok = 1'b1;
    end else begin
      e_ib   = m_ib; e_lh = m_lh; e_lv = m_lv;
      e_de   = m_de; e_hs = m_hs; e_vs = m_vs;
      e_cell = m_ib ? mb[m_row][m_col] : 0;
      rh = (int'(pix_h) - OH + 1024) % 1024;
      rv = (int'(pix_v) - OV + 1024) % 1024;
      m_ib  = (pix_de && int'(pix_h) >= OH && rh < COLS * 64 &&
               int'(pix_v) >= OV && rv < ROWS * 64) ? 1 : 0;
      m_row = rv / 64; m_col = rh / 64; m_lh = rh % 64; m_lv = rv % 64;
      m_de  = int'(pix_de); m_hs = int'(hsync_in); m_vs = int'(vsync_in);
      e_err = (wr_en && (int'(wr_row) >= ROWS || int'(wr_col) >= COLS ||
               wr_value == 2'b11 || clr_on != 0)) ? 1 : 0;
      if (wr_en && e_err == 0) mb[wr_row][wr_col] = int'(wr_value);
      if (clr_on != 0) begin
        mb[clr_idx / COLS][clr_idx % COLS] = 0;
        clr_idx++;
        if (clr_idx == ROWS * COLS) clr_on = 0;
      end else if (clear_req) begin
        clr_on = 1; clr_idx = 0;
      end
      e_busy = clr_on;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_in_board",  32'(in_board),   e_ib);
      chk("m_local_h",   32'(local_h),    e_lh);
      chk("m_local_v",   32'(local_v),    e_lv);
      chk("m_cell",      32'(cell_value), e_cell);
      chk("m_de_out",    32'(de_out),     e_de);
      chk("m_hsync_out", 32'(hsync_out),  e_hs);
      chk("m_vsync_out", 32'(vsync_out),  e_vs);
      chk("m_busy",      32'(busy),       e_busy);
      chk("m_wr_err",    32'(wr_err),     e_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_start(input int r, input int c, input int v);
    wr_en = 1'b1; wr_row = 4'(r); wr_col = 4'(c); wr_value = 2'(v);
    step();
  endtask

  task automatic scan(input int h, input int v);
    pix_h = 10'(h); pix_v = 10'(v); pix_de = 1'b1;
    step(); step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  logic [7:0] hs_pat, vs_pat, de_pat;
  int busy_cnt;

  initial begin
    rst = 1'b1; pix_h = '0; pix_v = '0; pix_de = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_value = '0; clear_req = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_err", 32'(wr_err), 0);
    chk("rst_in_board", 32'(in_board), 0);
    chk("rst_cell", 32'(cell_value), 0);
    chk("rst_hsync", 32'(hsync_out), 0);
    rst = 1'b0;

    // Write (2,3)=01, then look it up at pixel (197,154).
    wr_start(2, 3, 1);
    wr_en = 1'b0;
    chk("t1_no_err", 32'(wr_err), 0);
    scan(197, 154);
    chk("t1_in_board", 32'(in_board), 1);
    chk("t1_local_h", 32'(local_h), 5);
    chk("t1_local_v", 32'(local_v), 10);
    chk("t1_cell", 32'(cell_value), 1);

    // Off-board pixels: above the board, then right edge.
    scan(100, 5);
    chk("t2a_in_board", 32'(in_board), 0);
    chk("t2a_cell", 32'(cell_value), 0);
    scan(640, 200);
    chk("t2b_in_board", 32'(in_board), 0);
    chk("t2b_cell", 32'(cell_value), 0);
    hs_pat = 8'b1011_0010; vs_pat = 8'b0110_1001; de_pat = 8'b1100_0101;
    for (int i = 0; i < 8; i++) begin
      hsync_in = hs_pat[i]; vsync_in = vs_pat[i]; pix_de = de_pat[i];
      step();
      if (i >= 1) begin
        chk("t2_hsync_dly", 32'(hsync_out), 32'(hs_pat[i-1]));
        chk("t2_vsync_dly", 32'(vsync_out), 32'(vs_pat[i-1]));
        chk("t2_de_dly", 32'(de_out), 32'(de_pat[i-1]));
      end
    end
    hsync_in = 1'b0; vsync_in = 1'b0;

    // Rejected writes: illegal code, row out of range, column out of range.
    wr_start(0, 0, 3);
    chk("t3_err_code", 32'(wr_err), 1);
    wr_en = 1'b0;
    step();
    chk("t3_err_pulse_end", 32'(wr_err), 0);
    wr_start(7, 0, 1);
    chk("t3_err_row", 32'(wr_err), 1);
    wr_start(0, 10, 1);
    chk("t3_err_col", 32'(wr_err), 1);
    wr_en = 1'b0;
    scan(0, 16);
    chk("t3_in_board", 32'(in_board), 1);
    chk("t3_cell00", 32'(cell_value), 0);

    // Fill two corners, clear, and count busy cycles.
    wr_start(0, 0, 2);
    wr_start(6, 9, 1);
    wr_en = 1'b0;
    scan(579, 407);
    chk("t4_filled", 32'(cell_value), 1);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    busy_cnt = 0;
    wr_row = 4'd2; wr_col = 4'd2; wr_value = 2'd1;
    for (int k = 0; k < 200; k++) begin
      if (busy !== 1'b1) break;
      busy_cnt++;
      wr_en = (k == 5);
      clear_req = (k == 10);
      step();
      if (k == 5) chk("t4_wr_busy_err", 32'(wr_err), 1);
    end
    wr_en = 1'b0; clear_req = 1'b0;
    chk("t4_busy_cycles", 32'(busy_cnt), 70);
    chk("t4_busy_low", 32'(busy), 0);
    scan(579, 407);
    chk("t4_cell69", 32'(cell_value), 0);
    scan(0, 16);
    chk("t4_cell00", 32'(cell_value), 0);
    scan(129, 145);
    chk("t4_cell22", 32'(cell_value), 0);

    // Same-cycle read of a cell being written returns the old code.
    scan(65, 81);
    step();
    chk("t5_before", 32'(cell_value), 0);
    wr_start(1, 1, 2);
    chk("t5_same_cycle", 32'(cell_value), 0);
    wr_en = 1'b0;
    step();
    chk("t5_next_cycle", 32'(cell_value), 2);

    // Reset in the middle of a clear.
    wr_start(4, 4, 1);
    wr_en = 1'b0;
    scan(256, 272);
    chk("t6_filled", 32'(cell_value), 1);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (19) step();
    chk("t6_busy_mid", 32'(busy), 1);
    rst = 1'b1;
    step();
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_in_board", 32'(in_board), 0);
    chk("t6_rst_cell", 32'(cell_value), 0);
    chk("t6_rst_local_h", 32'(local_h), 0);
    chk("t6_rst_de", 32'(de_out), 0);
    rst = 1'b0;
    step(); step();
    chk("t6_cell44", 32'(cell_value), 0);
    chk("t6_in_board", 32'(in_board), 1);
    step();
    chk("t6_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
